// File: rtl/tile_loop_sequencer_pkg.sv
// Purpose : shared defaults, state encoding and helpers for the tile loop sequencer.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package tile_loop_sequencer_pkg;

    localparam int ROW_W_DEF        = 3;
    localparam int COL_W_DEF        = 5;
    localparam int K_W_DEF          = 5;
    localparam int DRAIN_CYCLES_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_WB    = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Width of a down-counter that has to hold cycles-1; never narrower than 1 bit.
    function automatic int drain_cnt_w(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/tile_loop_sequencer_loop_counter_3d.sv
// Purpose : nested inner/col/row wrap counters with run-time bounds (also usable by buffer address generators).
// Latency : indices update on the clock edge after an advance/clear request.
// Backpressure: none; the owner only advances when its handshake completes.
// Ports   : clk/rst, i_clear (zero all), i_adv_inner (inner+1), i_adv_tile (inner=0, col/row step),
//           i_*_max bounds, o_* indices, o_*_last flags (index equals its bound).
module tile_loop_sequencer_loop_counter_3d
    import tile_loop_sequencer_pkg::*;
#(
    parameter int ROW_W = ROW_W_DEF,
    parameter int COL_W = COL_W_DEF,
    parameter int K_W   = K_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_adv_inner,
    input  logic             i_adv_tile,
    input  logic [ROW_W-1:0] i_row_max,
    input  logic [COL_W-1:0] i_col_max,
    input  logic [K_W-1:0]   i_inner_max,
    output logic [ROW_W-1:0] o_row,
    output logic [COL_W-1:0] o_col,
    output logic [K_W-1:0]   o_inner,
    output logic             o_row_last,
    output logic             o_col_last,
    output logic             o_inner_last
);

    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_col;
    logic [K_W-1:0]   r_inner;

    // Bounds are compared before incrementing, so a max-value bound still
    // yields 2^W iterations without relying on overflow.
    assign o_row_last   = (r_row   == i_row_max);
    assign o_col_last   = (r_col   == i_col_max);
    assign o_inner_last = (r_inner == i_inner_max);

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_row   <= '0;
            r_col   <= '0;
            r_inner <= '0;
        end else if (i_adv_tile) begin
            // Row-major tile order: col is the faster index. The owner stops
            // advancing on the final tile, so row never wraps in practice.
            r_inner <= '0;
            if (o_col_last) begin
                r_col <= '0;
                r_row <= r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end else if (i_adv_inner) begin
            r_inner <= r_inner + 1'b1;
        end
    end

    assign o_row   = r_row;
    assign o_col   = r_col;
    assign o_inner = r_inner;

endmodule

// File: rtl/tile_loop_sequencer.sv
// Purpose : walks the tiled matmul loop nest, issues array steps, waits for the array to drain, then hands off each output tile.
// Latency : one step per accepted handshake; each tile costs (cfg_k+1) + DRAIN_CYCLES + 1 cycles with readies high.
// Backpressure: step_ready/wb_ready low hold indices and valid; enable low aborts to IDLE on the next edge.
// Ports   : clk/rst (sync, active-high); enable + cfg_* (latched only when a job starts);
//           step_valid/step_ready + tile indices/tile_first to the array; wb_valid/wb_ready to the output
//           buffer; busy, led_enable, led_finish status. Every output comes from registers.
module tile_loop_sequencer
    import tile_loop_sequencer_pkg::*;
#(
    parameter int ROW_W        = ROW_W_DEF,
    parameter int COL_W        = COL_W_DEF,
    parameter int K_W          = K_W_DEF,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [ROW_W-1:0] cfg_rows,
    input  logic [COL_W-1:0] cfg_cols,
    input  logic [K_W-1:0]   cfg_k,
    output logic             step_valid,
    input  logic             step_ready,
    output logic             tile_first,
    output logic [ROW_W-1:0] tile_row_idx,
    output logic [COL_W-1:0] tile_col_idx,
    output logic [K_W-1:0]   inner_loop_idx,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic             busy,
    output logic             led_enable,
    output logic             led_finish
);

    localparam int             DCW        = drain_cnt_w(DRAIN_CYCLES);
    localparam logic [DCW-1:0] DRAIN_LOAD = DCW'(DRAIN_CYCLES - 1);

    state_t           r_state;
    logic [ROW_W-1:0] r_cfg_rows;
    logic [COL_W-1:0] r_cfg_cols;
    logic [K_W-1:0]   r_cfg_k;
    logic [DCW-1:0]   r_drain_cnt;
    logic             r_step_valid;
    logic             r_wb_valid;
    logic             r_busy;
    logic             r_led_enable;
    logic             r_led_finish;

    logic             w_step_hs;
    logic             w_wb_hs;
    logic             w_clear;
    logic             w_adv_inner;
    logic             w_adv_tile;
    logic [ROW_W-1:0] w_row;
    logic [COL_W-1:0] w_col;
    logic [K_W-1:0]   w_inner;
    logic             w_row_last;
    logic             w_col_last;
    logic             w_inner_last;

    // r_step_valid is only ever high in RUN and r_wb_valid only in WB.
    assign w_step_hs = r_step_valid && step_ready;
    assign w_wb_hs   = r_wb_valid && wb_ready;

    // IDLE keeps the indices at zero; enable low zeroes them on abort or on leaving DONE.
    // Gating the advances with enable discards a handshake that coincides with an abort.
    assign w_clear     = (r_state == ST_IDLE) || !enable;
    assign w_adv_inner = enable && w_step_hs && !w_inner_last;
    assign w_adv_tile  = enable && w_wb_hs && !(w_row_last && w_col_last);

    tile_loop_sequencer_loop_counter_3d #(
        .ROW_W (ROW_W),
        .COL_W (COL_W),
        .K_W   (K_W)
    ) u_loop_cnt (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (w_clear),
        .i_adv_inner  (w_adv_inner),
        .i_adv_tile   (w_adv_tile),
        .i_row_max    (r_cfg_rows),
        .i_col_max    (r_cfg_cols),
        .i_inner_max  (r_cfg_k),
        .o_row        (w_row),
        .o_col        (w_col),
        .o_inner      (w_inner),
        .o_row_last   (w_row_last),
        .o_col_last   (w_col_last),
        .o_inner_last (w_inner_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cfg_rows   <= '0;
            r_cfg_cols   <= '0;
            r_cfg_k      <= '0;
            r_drain_cnt  <= '0;
            r_step_valid <= 1'b0;
            r_wb_valid   <= 1'b0;
            r_busy       <= 1'b0;
            r_led_enable <= 1'b0;
            r_led_finish <= 1'b0;
        end else begin
            r_led_enable <= enable;
            case (r_state)
                ST_IDLE: begin
                    if (enable) begin
                        r_cfg_rows   <= cfg_rows;
                        r_cfg_cols   <= cfg_cols;
                        r_cfg_k      <= cfg_k;
                        r_state      <= ST_RUN;
                        r_step_valid <= 1'b1;
                        r_busy       <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!enable) begin
                        r_state      <= ST_IDLE;
                        r_step_valid <= 1'b0;
                        r_busy       <= 1'b0;
                    end else if (w_step_hs && w_inner_last) begin
                        r_state      <= ST_DRAIN;
                        r_step_valid <= 1'b0;
                        r_drain_cnt  <= DRAIN_LOAD;
                    end
                end
                ST_DRAIN: begin
                    // Loaded with DRAIN_CYCLES-1 and left at 0, so DRAIN lasts exactly DRAIN_CYCLES cycles.
                    if (!enable) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_drain_cnt == '0) begin
                        r_state    <= ST_WB;
                        r_wb_valid <= 1'b1;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - 1'b1;
                    end
                end
                ST_WB: begin
                    if (!enable) begin
                        r_state    <= ST_IDLE;
                        r_wb_valid <= 1'b0;
                        r_busy     <= 1'b0;
                    end else if (w_wb_hs) begin
                        r_wb_valid <= 1'b0;
                        if (w_row_last && w_col_last) begin
                            r_state      <= ST_DONE;
                            r_busy       <= 1'b0;
                            r_led_finish <= 1'b1;
                        end else begin
                            r_state      <= ST_RUN;
                            r_step_valid <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (!enable) begin
                        r_state      <= ST_IDLE;
                        r_led_finish <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_step_valid <= 1'b0;
                    r_wb_valid   <= 1'b0;
                    r_busy       <= 1'b0;
                    r_led_finish <= 1'b0;
                end
            endcase
        end
    end

    assign step_valid     = r_step_valid;
    assign wb_valid       = r_wb_valid;
    assign busy           = r_busy;
    assign led_enable     = r_led_enable;
    assign led_finish     = r_led_finish;
    assign tile_row_idx   = w_row;
    assign tile_col_idx   = w_col;
    assign inner_loop_idx = w_inner;
    assign tile_first     = r_busy && (w_inner == '0);

endmodule

// File: tb/tb_tile_loop_sequencer.sv
// Purpose : self-checking bench for tile_loop_sequencer (vector table plus directed abort/reset sequences).
// Latency : n/a.
// Backpressure: bench drives step_ready/wb_ready patterns including toggling and long writeback stalls.
module tb_tile_loop_sequencer;

    localparam int ROW_W = 3;
    localparam int COL_W = 5;
    localparam int K_W   = 5;
    localparam int DRAIN = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic [ROW_W-1:0] cfg_rows;
    logic [COL_W-1:0] cfg_cols;
    logic [K_W-1:0]   cfg_k;
    logic             step_valid;
    logic             step_ready;
    logic             tile_first;
    logic [ROW_W-1:0] tile_row_idx;
    logic [COL_W-1:0] tile_col_idx;
    logic [K_W-1:0]   inner_loop_idx;
    logic             wb_valid;
    logic             wb_ready;
    logic             busy;
    logic             led_enable;
    logic             led_finish;

    always #5 clk = ~clk;

    tile_loop_sequencer #(
        .ROW_W        (ROW_W),
        .COL_W        (COL_W),
        .K_W          (K_W),
        .DRAIN_CYCLES (DRAIN)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .cfg_rows       (cfg_rows),
        .cfg_cols       (cfg_cols),
        .cfg_k          (cfg_k),
        .step_valid     (step_valid),
        .step_ready     (step_ready),
        .tile_first     (tile_first),
        .tile_row_idx   (tile_row_idx),
        .tile_col_idx   (tile_col_idx),
        .inner_loop_idx (inner_loop_idx),
        .wb_valid       (wb_valid),
        .wb_ready       (wb_ready),
        .busy           (busy),
        .led_enable     (led_enable),
        .led_finish     (led_finish)
    );

    typedef struct {
        int row;
        int col;
        int inner;
    } idx_t;

    typedef struct {
        int rows;
        int cols;
        int k;
        bit toggle;
        bit stall;
        int exp_steps;
        int exp_wbs;
        int exp_cycles;
    } vec_t;

    idx_t step_q[$];
    idx_t wb_q[$];
    vec_t vecs[6];

    int checks    = 0;
    int errors    = 0;
    int step_cnt  = 0;
    int wb_cnt    = 0;
    int first_cnt = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Reference loop nest: row-major tiles, K innermost; writeback reports the finished tile.
    task automatic push_job(input int r, input int c, input int k);
        idx_t s;
        for (int ri = 0; ri <= r; ri++) begin
            for (int ci = 0; ci <= c; ci++) begin
                for (int ki = 0; ki <= k; ki++) begin
                    s.row = ri; s.col = ci; s.inner = ki;
                    step_q.push_back(s);
                end
                s.row = ri; s.col = ci; s.inner = k;
                wb_q.push_back(s);
            end
        end
    endtask

    task automatic clear_counts();
        step_cnt = 0; wb_cnt = 0; first_cnt = 0;
    endtask

    // Monitor: compares every handshake against the scoreboard and checks index hold on stalls.
    initial begin
        idx_t e;
        idx_t hold;
        bit   hold_vld;
        hold_vld = 1'b0;
        hold = '{0, 0, 0};
        forever begin
            @(negedge clk);
            if (hold_vld && step_valid) begin
                chk("hold_row",   int'(tile_row_idx),   hold.row);
                chk("hold_col",   int'(tile_col_idx),   hold.col);
                chk("hold_inner", int'(inner_loop_idx), hold.inner);
            end
            hold_vld   = step_valid && !step_ready;
            hold.row   = int'(tile_row_idx);
            hold.col   = int'(tile_col_idx);
            hold.inner = int'(inner_loop_idx);
            if (step_valid && step_ready) begin
                step_cnt++;
                if (tile_first) first_cnt++;
                if (step_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL step_extra actual=(%0d,%0d,%0d) required=none",
                             tile_row_idx, tile_col_idx, inner_loop_idx);
                end else begin
                    e = step_q.pop_front();
                    chk("step_row",   int'(tile_row_idx),   e.row);
                    chk("step_col",   int'(tile_col_idx),   e.col);
                    chk("step_inner", int'(inner_loop_idx), e.inner);
                    chk("step_first", int'(tile_first),     int'(e.inner == 0));
                end
            end
            if (wb_valid && wb_ready) begin
                wb_cnt++;
                if (wb_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wb_extra actual=(%0d,%0d) required=none", tile_row_idx, tile_col_idx);
                end else begin
                    e = wb_q.pop_front();
                    chk("wb_row",   int'(tile_row_idx),   e.row);
                    chk("wb_col",   int'(tile_col_idx),   e.col);
                    chk("wb_inner", int'(inner_loop_idx), e.inner);
                end
            end
        end
    end

    task automatic wait_finish(input int limit, output int n);
        n = 0;
        while (!led_finish && n < limit) begin
            @(posedge clk); #1; n++;
        end
        chk("finish_seen", int'(led_finish), 1);
    endtask

    task automatic end_job(input string tag);
        enable = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_idle_finish"}, int'(led_finish), 0);
        chk({tag, "_idle_busy"},   int'(busy),       0);
        chk({tag, "_idle_row"},    int'(tile_row_idx),   0);
        chk({tag, "_idle_inner"},  int'(inner_loop_idx), 0);
    endtask

    task automatic run_vec(input int id, input vec_t v);
        int    n;
        int    stall;
        string t;
        t = $sformatf("v%0d", id);
        cfg_rows   = ROW_W'(v.rows);
        cfg_cols   = COL_W'(v.cols);
        cfg_k      = K_W'(v.k);
        step_ready = 1'b1;
        wb_ready   = 1'b1;
        stall      = 0;
        clear_counts();
        push_job(v.rows, v.cols, v.k);
        enable = 1'b1;
        n = 0;
        while (!led_finish && n < 20000) begin
            @(posedge clk); #1; n++;
            if (v.toggle) step_ready = !step_ready;
            if (v.stall && wb_valid && stall < 10) begin
                chk({t, "_stall_row"},  int'(tile_row_idx), 0);
                chk({t, "_stall_col"},  int'(tile_col_idx), 0);
                chk({t, "_stall_step"}, int'(step_valid),   0);
                wb_ready = 1'b0;
                stall++;
            end else begin
                wb_ready = 1'b1;
            end
        end
        chk({t, "_finish_seen"}, int'(led_finish), 1);
        chk({t, "_cycles"},      n - 1,            v.exp_cycles);
        chk({t, "_steps"},       step_cnt,         v.exp_steps);
        chk({t, "_wbs"},         wb_cnt,           v.exp_wbs);
        chk({t, "_firsts"},      first_cnt,        v.exp_wbs);
        chk({t, "_stepq_left"},  step_q.size(),    0);
        chk({t, "_wbq_left"},    wb_q.size(),      0);
        chk({t, "_done_row"},    int'(tile_row_idx),   v.rows);
        chk({t, "_done_col"},    int'(tile_col_idx),   v.cols);
        chk({t, "_done_inner"},  int'(inner_loop_idx), v.k);
        chk({t, "_done_busy"},   int'(busy),       0);
        chk({t, "_led_enable"},  int'(led_enable), 1);
        step_ready = 1'b1;
        wb_ready   = 1'b1;
        end_job(t);
    endtask

    initial begin
        int n;

        // {rows, cols, k, toggle step_ready, 10-cycle wb stall, steps, writebacks, enable-edge to led_finish}
        vecs[0] = '{1, 1, 2, 1'b0, 1'b0, 12, 4, 32};
        vecs[1] = '{1, 1, 2, 1'b1, 1'b0, 12, 4, 41};
        vecs[2] = '{1, 1, 2, 1'b0, 1'b1, 12, 4, 42};
        vecs[3] = '{0, 0, 0, 1'b0, 1'b0, 1, 1, 6};
        vecs[4] = '{2, 0, 1, 1'b0, 1'b0, 6, 3, 21};
        vecs[5] = '{7, 31, 31, 1'b0, 1'b0, 8192, 256, 9472};

        rst = 1'b1; enable = 1'b1; step_ready = 1'b1; wb_ready = 1'b1;
        cfg_rows = '0; cfg_cols = '0; cfg_k = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_step_valid", int'(step_valid), 0);
        chk("rst_wb_valid",   int'(wb_valid),   0);
        chk("rst_busy",       int'(busy),       0);
        chk("rst_led_enable", int'(led_enable), 0);
        chk("rst_led_finish", int'(led_finish), 0);
        chk("rst_row",        int'(tile_row_idx),   0);
        chk("rst_col",        int'(tile_col_idx),   0);
        chk("rst_inner",      int'(inner_loop_idx), 0);
        chk("rst_tile_first", int'(tile_first),     0);
        rst = 1'b0; enable = 1'b0;
        @(posedge clk); #1;

        for (int v = 0; v < 6; v++) run_vec(v, vecs[v]);

        // Abort during DRAIN of tile (0,1), then restart from scratch.
        cfg_rows = 3'd1; cfg_cols = 5'd1; cfg_k = 5'd2;
        clear_counts();
        push_job(1, 1, 2);
        enable = 1'b1;
        n = 0;
        while (step_cnt < 6 && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk("abort_reach_steps", step_cnt, 6);
        chk("abort_drain_busy",  int'(busy),       1);
        chk("abort_drain_step",  int'(step_valid), 0);
        chk("abort_drain_col",   int'(tile_col_idx), 1);
        enable = 1'b0;
        @(posedge clk); #1;
        chk("abort_busy",    int'(busy),       0);
        chk("abort_wb",      int'(wb_valid),   0);
        chk("abort_step",    int'(step_valid), 0);
        chk("abort_finish",  int'(led_finish), 0);
        chk("abort_row",     int'(tile_row_idx),   0);
        chk("abort_col",     int'(tile_col_idx),   0);
        chk("abort_inner",   int'(inner_loop_idx), 0);
        step_q.delete(); wb_q.delete();
        clear_counts();
        push_job(1, 1, 2);
        enable = 1'b1;
        wait_finish(200, n);
        chk("reenable_steps", step_cnt, 12);
        chk("reenable_wbs",   wb_cnt,   4);
        chk("reenable_q",     step_q.size() + wb_q.size(), 0);
        end_job("reenable");

        // Reset pulse in RUN with inner=1; the restarted job must ignore later cfg changes.
        clear_counts();
        push_job(1, 1, 2);
        enable = 1'b1;
        n = 0;
        while (!(step_valid && inner_loop_idx == 5'd1) && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("rst_mid_reach_inner", int'(inner_loop_idx), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_step",       int'(step_valid), 0);
        chk("rst_mid_wb",         int'(wb_valid),   0);
        chk("rst_mid_busy",       int'(busy),       0);
        chk("rst_mid_led_enable", int'(led_enable), 0);
        chk("rst_mid_finish",     int'(led_finish), 0);
        chk("rst_mid_inner",      int'(inner_loop_idx), 0);
        chk("rst_mid_first",      int'(tile_first),     0);
        rst = 1'b0;
        step_q.delete(); wb_q.delete();
        clear_counts();
        push_job(1, 1, 2);
        @(posedge clk); #1;
        chk("rst_restart_busy", int'(busy), 1);
        cfg_rows = 3'd0; cfg_cols = 5'd0; cfg_k = 5'd0;
        wait_finish(200, n);
        chk("cfgchg_steps", step_cnt, 12);
        chk("cfgchg_wbs",   wb_cnt,   4);
        chk("cfgchg_q",     step_q.size() + wb_q.size(), 0);
        chk("cfgchg_row",   int'(tile_row_idx), 1);
        end_job("cfgchg");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
